mem_subword_ctrl: RTL

MEM_SUBWORD_CTRL -- requirements
Module: mem_subword_ctrl

---
 rtl/mem_subword_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_subword_ctrl.sv
// Sub-word load/store sequencer in front of a 32-bit word memory.
// Sub-word stores do a read-modify-write through a one-word buffer.
module mem_subword_ctrl (
  input  logic        clock_me,
  input  logic        resetn,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        misalign,
  output logic [31:0] mem_addr,
  output logic        mem_wmem,
  output logic [31:0] mem_in,
  input  logic [31:0] mem_out
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        mis_q, mis_d;
  logic [31:0] buf_q, buf_d;

  logic        req_mis;
  logic [4:0]  boff;
  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext;
  logic [31:0] merged;

  assign req_mis = (size == 2'b11) ||
                   (size == 2'b01 && addr[0]) ||
                   (size == 2'b10 && addr[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: if (req) begin
        we_d    = we;
        size_d  = size;
        sext_d  = sign_ext;
        addr_d  = addr;
        wdata_d = wdata;
        mis_d   = req_mis;
        if (req_mis)                    state_d = DONE;
        else if (!we || size != 2'b10)  state_d = RD;
        else                            state_d = WR;
      end
      RD: begin
        buf_d   = mem_out;
        state_d = we_q ? WR : DONE;
      end
      WR:      state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_me) begin
    if (!resetn) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      buf_q   <= buf_d;
    end
  end

  // Little-endian lane selection shared by load extract and store merge.
  assign boff    = {addr_q[1:0], 3'b000};
  assign shifted = buf_q >> boff;
  assign lane_b  = shifted[7:0];
  assign lane_h  = addr_q[1] ? buf_q[31:16] : buf_q[15:0];

  always_comb begin
    case (size_q)
      2'b00:   ext = {{24{sext_q & lane_b[7]}}, lane_b};
      2'b01:   ext = {{16{sext_q & lane_h[15]}}, lane_h};
      default: ext = buf_q;
    endcase
  end

  always_comb begin
    merged = buf_q;
    case (size_q)
      2'b00:   merged[boff +: 8] = wdata_q[7:0];
      2'b01:   if (addr_q[1]) merged[31:16] = wdata_q[15:0];
               else           merged[15:0]  = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign ready    = (state_q == DONE) && resetn;
  assign misalign = ready && mis_q;
  assign rdata    = (ready && !we_q && !mis_q) ? ext : 32'h0;
  // Write port takes a word index, read port a byte address.
  assign mem_addr = (state_q == RD) ? {addr_q[31:2], 2'b00} :
                    (state_q == WR) ? (addr_q >> 2) : 32'h0;
  assign mem_wmem = (state_q == WR) && resetn;
  assign mem_in   = (state_q == WR) ? merged : 32'h0;

endmodule
